operand_fetch: RTL
==================

# operand_fetch

Issue-side consumer of the `regfile` lock/read interface. Takes decoded instructions over a valid/ready handshake and reads up to three source operands. Stalls while any used source or the destination is locked, and forwards same-cycle writeback data. On dispatch it asserts `wr_lock_en_o` for the destination and presents operands to execute through a registered valid/ready output. It sits between decode and execute, driving the regfile's `rs*_addr_i`/`wr_lock_*` pins and snooping its `wr_unlock_*` pins.

## Interface

- `PAYLOAD_W`, 32, opaque decoded-instruction payload width passed through unchanged
- `NUM_REGS`, `XLEN` from `maverickOne_pkg`; `AW = $clog2(NUM_REGS)`
- Clock and reset: one clock; reset is asynchronous and active-low (`clk_i`, `arst_ni`).
- `clk_i` in 1 clock
- `arst_ni` in 1 async active-low reset
- `instr_valid_i` in 1 decode has instruction
- `instr_ready_o` out 1 entry can accept
- `instr_payload_i` in PAYLOAD_W payload
- `instr_rs_use_i` in 3 bit k = source k+1 used
- `instr_rs1_addr_i`/`instr_rs2_addr_i`/`instr_rs3_addr_i` in AW each source register
- `instr_rd_write_i` in 1 instruction writes rd
- `instr_rd_addr_i` in AW destination
- `rs1_addr_o`/`rs2_addr_o`/`rs3_addr_o` out AW to regfile read ports
- `rs1_data_i`/`rs2_data_i`/`rs3_data_i` in XLEN combinational regfile read data
- `locks_i` in NUM_REGS regfile lock vector
- `wr_lock_en_o` out 1 lock request
- `wr_lock_addr_o` out AW lock address
- `wr_unlock_en_i` in 1 writeback snoop
- `wr_unlock_addr_i` in AW writeback snoop
- `wr_unlock_data_i` in XLEN writeback snoop
- `flush_i` in 1 discard all held instructions
- `issue_valid_o` out 1 operands ready
- `issue_ready_i` in 1 execute accepts
- `issue_payload_o` out PAYLOAD_W registered payload
- `issue_rd_write_o` out 1 registered rd write flag
- `issue_rd_addr_o` out AW registered rd address
- `issue_rs1_data_o`/`issue_rs2_data_o`/`issue_rs3_data_o` out XLEN registered operands

## Operation

- Two stages: ENTRY register (holds accepted instruction) and OUT register (holds issued operands); each has a valid bit.
- Accept: `instr_ready_o = !entry_v || dispatch`; capture on `instr_valid_i && instr_ready_o`.
- `rs*_addr_o` driven from ENTRY at all times; all zero when ENTRY is empty.
- A source k is blocked when it is used, its address is non-zero, `locks_i[addr]` is set, and no same-cycle unlock to that address is in flight.
- An unlock is in flight when `wr_unlock_en_i` is set and `wr_unlock_addr_i` equals the address.
- The destination is blocked (WAW) when `rd_write` is set, rd is non-zero, `locks_i[rd]` is set, and no same-cycle unlock to rd is in flight.
- `hazard` = any source blocked or destination blocked.
- `dispatch = entry_v && !hazard && (!out_v || issue_ready_i) && !flush_i`.
- On dispatch, OUT captures the payload, rd fields and operands, and `out_v` is set.
- Each captured operand is selected in priority order:
  - 0 when the address is 0 or the source is unused;
  - otherwise `wr_unlock_data_i` when an unlock to that address is in flight;
  - otherwise `rs*_data_i`.
- `wr_lock_en_o = dispatch && rd_write && rd != 0`; `wr_lock_addr_o` = ENTRY rd (0 when not locking).
- A lock and an unlock to the same address in the same cycle are legal; the regfile's lock wins, so rd stays locked.
- OUT holds stable while `issue_valid_o && !issue_ready_i`; cleared on handshake unless a new dispatch occurs the same cycle.
- `flush_i`:
  - next edge clears `entry_v` and `out_v`;
  - no lock is issued that cycle;
  - input is not accepted that cycle (`instr_ready_o` = 0);
  - locks already taken are not released (the writeback/kill path owns release).
- Reset: `entry_v` = `out_v` = 0; all registered outputs are 0; `instr_ready_o` = 1; `wr_lock_en_o` = 0. Reset mid-stall drops both instructions silently.

## Timing

- No-hazard latency: accept at edge N, dispatch and lock in cycle N, `issue_valid_o` high from edge N+1.
- Throughput is 1 instruction/cycle with no hazards and `issue_ready_i` held high.
- Dependent back-to-back (B reads A's rd):
  - B enters ENTRY on the edge A dispatches;
  - from that cycle `locks_i[rd]` is set, so B stalls with no gap.
- A stalled instruction dispatches in the cycle its producer's unlock appears on the snoop, with the forwarded data.
- Backpressure: with `issue_ready_i` = 0 and OUT full, ENTRY holds and `instr_ready_o` = 0.

## Configuration

- `OPERAND_FETCH_BYPASS_EN` defined:
  - same-cycle unlock clears a hazard;
  - unlock data is forwarded into OUT.
- Not defined:
  - snoop inputs are ignored;
  - hazard holds until `locks_i` clears;
  - dispatch happens the cycle after the unlock edge, with operands read from the regfile (+1 cycle per dependency).

## Test plan

- Reset:
  - stimulus: assert `arst_ni`=0 mid-stall;
  - response: `issue_valid_o`=0, `instr_ready_o`=1, `wr_lock_en_o`=0; after release, a fresh instruction issues normally.
- Independent stream:
  - stimulus: 8 back-to-back instructions with rd 1..8 reading x0, `issue_ready_i`=1;
  - response: 8 consecutive `issue_valid_o` cycles; `wr_lock_addr_o` = 1..8; operands all 0.
- RAW with bypass:
  - stimulus: A writes x5 and dispatches; B reads x5; three cycles later unlock x5 with data 0xDEADBEEF;
  - response: B dispatches in the unlock cycle with `issue_rs1_data_o` = 0xDEADBEEF; without the macro it dispatches one cycle later with the same value.
- WAW:
  - stimulus: x7 locked; instruction writes x7;
  - response: stalls with no `wr_lock_en_o` until the unlock of x7, then locks x7 in the same cycle, and `locks_i[7]` remains set.
- Backpressure:
  - stimulus: `issue_ready_i`=0 for 5 cycles with 2 instructions queued;
  - response: OUT stable; `instr_ready_o`=0; no second lock until OUT drains.
- Flush:
  - stimulus: `flush_i`=1 with ENTRY and OUT full;
  - response: next cycle `issue_valid_o`=0, no `wr_lock_en_o` in the flush cycle, and `instr_ready_o`=1 after.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: two-stage (ENTRY -> OUT) operand fetch between decode and execute, locking rd on dispatch.
// Define OPERAND_FETCH_BYPASS_EN to let a same-cycle writeback clear hazards and forward its data.
package maverickOne_pkg;
    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;
endpackage

module operand_fetch
    import maverickOne_pkg::*;
#(
    parameter int PAYLOAD_W = 32,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [PAYLOAD_W-1:0] instr_payload_i,
    input  logic [2:0]           instr_rs_use_i,
    input  logic [AW-1:0]        instr_rs1_addr_i,
    input  logic [AW-1:0]        instr_rs2_addr_i,
    input  logic [AW-1:0]        instr_rs3_addr_i,
    input  logic                 instr_rd_write_i,
    input  logic [AW-1:0]        instr_rd_addr_i,
    output logic [AW-1:0]        rs1_addr_o,
    output logic [AW-1:0]        rs2_addr_o,
    output logic [AW-1:0]        rs3_addr_o,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic [XLEN-1:0]      rs3_data_i,
    input  logic [NUM_REGS-1:0]  locks_i,
    output logic                 wr_lock_en_o,
    output logic [AW-1:0]        wr_lock_addr_o,
    input  logic                 wr_unlock_en_i,
    input  logic [AW-1:0]        wr_unlock_addr_i,
    input  logic [XLEN-1:0]      wr_unlock_data_i,
    input  logic                 flush_i,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [PAYLOAD_W-1:0] issue_payload_o,
    output logic                 issue_rd_write_o,
    output logic [AW-1:0]        issue_rd_addr_o,
    output logic [XLEN-1:0]      issue_rs1_data_o,
    output logic [XLEN-1:0]      issue_rs2_data_o,
    output logic [XLEN-1:0]      issue_rs3_data_o
);

    // Valid/ready on both sides: a transfer occurs on a rising edge where valid and ready are both
    // high; valid never depends on ready, and the sender holds valid and data until the transfer.

    logic                 entry_v;
    logic [PAYLOAD_W-1:0] entry_payload;
    logic [2:0]           entry_use;
    logic [2:0][AW-1:0]   entry_rs;
    logic                 entry_rd_write;
    logic [AW-1:0]        entry_rd;
    logic                 out_v;
    logic [2:0][XLEN-1:0] out_data;

    logic                 snoop_en;
    logic [AW-1:0]        snoop_addr;
    logic [XLEN-1:0]      snoop_data;
    logic [2:0][XLEN-1:0] rf_data;
    logic [2:0][XLEN-1:0] src_sel;
    logic [2:0]           src_blocked;
    logic                 rd_blocked;
    logic                 hazard;
    logic                 dispatch;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign snoop_en   = wr_unlock_en_i;
    assign snoop_addr = wr_unlock_addr_i;
    assign snoop_data = wr_unlock_data_i;
`else
    // Without bypass the stage waits for locks_i to drop and then reads the regfile.
    logic snoop_unused;
    assign snoop_unused = ^{wr_unlock_en_i, wr_unlock_addr_i, wr_unlock_data_i};
    assign snoop_en     = 1'b0;
    assign snoop_addr   = '0;
    assign snoop_data   = '0;
`endif

    assign rf_data = {rs3_data_i, rs2_data_i, rs1_data_i};

    always_comb begin
        src_blocked = '0;
        src_sel     = '0;
        for (int k = 0; k < 3; k++) begin
            if (entry_use[k] && (entry_rs[k] != '0)) begin
                if (snoop_en && (snoop_addr == entry_rs[k])) begin
                    src_sel[k] = snoop_data;
                end else begin
                    src_sel[k]     = rf_data[k];
                    src_blocked[k] = locks_i[entry_rs[k]];
                end
            end
        end
    end

    assign rd_blocked = entry_rd_write && (entry_rd != '0) && locks_i[entry_rd]
                        && !(snoop_en && (snoop_addr == entry_rd));
    assign hazard     = (|src_blocked) || rd_blocked;
    assign dispatch   = entry_v && !hazard && (!out_v || issue_ready_i) && !flush_i;

    assign instr_ready_o  = (!entry_v || dispatch) && !flush_i;
    assign rs1_addr_o     = entry_v ? entry_rs[0] : '0;
    assign rs2_addr_o     = entry_v ? entry_rs[1] : '0;
    assign rs3_addr_o     = entry_v ? entry_rs[2] : '0;
    assign wr_lock_en_o   = dispatch && entry_rd_write && (entry_rd != '0);
    assign wr_lock_addr_o = wr_lock_en_o ? entry_rd : '0;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            entry_v        <= 1'b0;
            entry_payload  <= '0;
            entry_use      <= '0;
            entry_rs       <= '0;
            entry_rd_write <= 1'b0;
            entry_rd       <= '0;
        end else if (flush_i) begin
            entry_v <= 1'b0;
        end else if (instr_valid_i && instr_ready_o) begin
            entry_v        <= 1'b1;
            entry_payload  <= instr_payload_i;
            entry_use      <= instr_rs_use_i;
            entry_rs       <= {instr_rs3_addr_i, instr_rs2_addr_i, instr_rs1_addr_i};
            entry_rd_write <= instr_rd_write_i;
            entry_rd       <= instr_rd_addr_i;
        end else if (dispatch) begin
            entry_v <= 1'b0;
        end
    end

    // A new dispatch overrides the clear that an execute handshake would otherwise cause.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_v            <= 1'b0;
            issue_payload_o  <= '0;
            issue_rd_write_o <= 1'b0;
            issue_rd_addr_o  <= '0;
            out_data         <= '0;
        end else if (flush_i) begin
            out_v <= 1'b0;
        end else if (dispatch) begin
            out_v            <= 1'b1;
            issue_payload_o  <= entry_payload;
            issue_rd_write_o <= entry_rd_write;
            issue_rd_addr_o  <= entry_rd;
            out_data         <= src_sel;
        end else if (issue_ready_i) begin
            out_v <= 1'b0;
        end
    end

    assign issue_valid_o    = out_v;
    assign issue_rs1_data_o = out_data[0];
    assign issue_rs2_data_o = out_data[1];
    assign issue_rs3_data_o = out_data[2];

endmodule
